// File: rtl/sonic_echo_responder.sv
// Sensor-side emulation of an ultrasonic ranger: answers a trigger pulse with an echo whose width encodes dist_cm.
// Optional macro SONIC_ECHO_CNT_EN adds a saturating echo_cnt output counting completed echoes.
module sonic_echo_responder #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000,
    parameter int DIST_W      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DIST_W-1:0] dist_cm,
    input  logic              obj_present,
    output logic              echo,
    output logic              busy,
    output logic              trig_err
`ifdef SONIC_ECHO_CNT_EN
    ,
    output logic [15:0]       echo_cnt
`endif
);

    localparam int CYC_PER_US  = CLK_FREQ_HZ / 1000000;
    localparam int PRE_W       = $clog2(CYC_PER_US);
    localparam int TRIG_THRESH = TRIG_MIN_US * CYC_PER_US;
    localparam int CNT_W       = $clog2(TRIG_THRESH + 1);

    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CYC_PER_US - 1);
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(TRIG_THRESH);
    localparam logic [15:0]      BURST_LIM = 16'(BURST_US - 1);
    localparam logic [15:0]      HOLD_LIM  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]      TIMEOUT_W = 16'(TIMEOUT_US);
    localparam logic [15:0]      MIN_W     = 16'(MIN_CM * US_PER_CM);
    localparam logic [15:0]      UPC_C     = 16'(US_PER_CM);
    localparam logic [15:0]      MIN_D     = 16'(MIN_CM);
    localparam logic [15:0]      MAX_D     = 16'(MAX_CM);

    generate
        if (CYC_PER_US < 2 || TIMEOUT_US >= 65536 || MAX_CM * US_PER_CM >= 65536 ||
            BURST_US < 1 || BURST_US > 65536 || HOLDOFF_US < 1 || HOLDOFF_US > 65536 ||
            MIN_CM < 1 || TRIG_MIN_US < 1 || DIST_W > 16) begin : g_param_err
            $error("sonic_echo_responder: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_trig_meta;
    logic               r_trig_s;
    logic               r_trig_d;
    logic [PRE_W-1:0]   r_pre;
    logic [15:0]        r_us;
    logic [CNT_W-1:0]   r_hi_cnt;
    logic [15:0]        r_width_us;
    logic               r_echo;
    logic               r_busy;
    logic               r_trig_err;
    logic               w_trig_rise;
    logic               w_trig_fall;
    logic               w_tick;
    logic               w_done;
    logic               w_accept;
    logic               w_reject;
    logic [15:0]        w_limit;
    logic [15:0]        w_dist16;
    logic [15:0]        w_width_calc;

    assign w_trig_rise = r_trig_s & ~r_trig_d;
    assign w_trig_fall = ~r_trig_s & r_trig_d;
    assign w_tick      = (r_pre == PRE_MAX);
    assign w_done      = w_tick && (r_us == w_limit);
    assign w_dist16    = 16'(dist_cm);

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_meta <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_d    <= 1'b0;
        end else begin
            r_trig_meta <= trigger;
            r_trig_s    <= r_trig_meta;
            r_trig_d    <= r_trig_s;
        end
    end

    always_comb begin
        w_width_calc = 16'd0;
        if (!obj_present || (w_dist16 > MAX_D)) begin
            w_width_calc = TIMEOUT_W;
        end else if (w_dist16 < MIN_D) begin
            w_width_calc = MIN_W;
        end else begin
            w_width_calc = w_dist16 * UPC_C;
        end
    end

    // Final-microsecond index for each timed state; every interval is N whole microseconds
    always_comb begin
        w_limit = 16'd0;
        case (r_state)
            S_BURST:   w_limit = BURST_LIM;
            S_ECHO:    w_limit = r_width_us - 16'd1;
            S_HOLDOFF: w_limit = HOLD_LIM;
            default:   w_limit = 16'd0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig_rise) begin
                    w_next = S_TRIG_HI;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_TRIG_HI: begin
                if (w_trig_fall) begin
                    if (r_hi_cnt >= THRESH_C) begin
                        w_accept = 1'b1;
                        w_next   = S_BURST;
                    end else begin
                        w_reject = 1'b1;
                        w_next   = S_IDLE;
                    end
                end else begin
                    w_next = S_TRIG_HI;
                end
            end
            S_BURST: begin
                if (w_done) begin
                    w_next = S_ECHO;
                end else begin
                    w_next = S_BURST;
                end
            end
            S_ECHO: begin
                if (w_done) begin
                    w_next = S_HOLDOFF;
                end else begin
                    w_next = S_ECHO;
                end
            end
            S_HOLDOFF: begin
                if (w_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_HOLDOFF;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Prescaler and microsecond counter restart on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_us  <= 16'd0;
        end else if (w_next != r_state) begin
            r_pre <= '0;
            r_us  <= 16'd0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_us  <= r_us + 16'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Trigger-high width; IDLE preloads 1 so the rise cycle itself is counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_hi_cnt <= CNT_W'(1);
        end else if ((r_state == S_TRIG_HI) && r_trig_s && (r_hi_cnt != THRESH_C)) begin
            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
        end else begin
            r_hi_cnt <= r_hi_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width_us <= 16'd0;
        end else if (w_accept) begin
            r_width_us <= w_width_calc;
        end else begin
            r_width_us <= r_width_us;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b0;
        end else begin
            r_echo     <= (r_state == S_ECHO);
            r_busy     <= (r_state inside {S_BURST, S_ECHO, S_HOLDOFF});
            r_trig_err <= w_reject;
        end
    end

    assign echo     = r_echo;
    assign busy     = r_busy;
    assign trig_err = r_trig_err;

`ifdef SONIC_ECHO_CNT_EN
    logic [15:0] r_echo_cnt;

    // r_echo high while the FSM has left ECHO means echo falls on this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_cnt <= 16'd0;
        end else if (r_echo && (r_state != S_ECHO) && (r_echo_cnt != 16'hFFFF)) begin
            r_echo_cnt <= r_echo_cnt + 16'd1;
        end else begin
            r_echo_cnt <= r_echo_cnt;
        end
    end

    assign echo_cnt = r_echo_cnt;
`endif

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Directed bench for sonic_echo_responder with a cycle-level reference model built from the protocol timing rules.
module tb_sonic_echo_responder;

    localparam int C     = 2;     // cycles per microsecond (2 MHz clock)
    localparam int B_US  = 20;
    localparam int H_US  = 50;
    localparam int TMIN  = 10;
    localparam int UPC   = 3;
    localparam int MINC  = 2;
    localparam int MAXC  = 400;
    localparam int TO_US = 1500;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trigger = 1'b0;
    logic [8:0] dist_cm = 9'd10;
    logic       obj_present = 1'b1;
    logic       echo;
    logic       busy;
    logic       trig_err;
`ifdef SONIC_ECHO_CNT_EN
    logic [15:0] echo_cnt;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rises = 0;

    // model state: absolute edge numbers of expected output windows
    int  m_rise = 0;
    bit  m_in_trig = 1'b0;
    bit  m_prev = 1'b0;
    int  m_idle_edge = 0;
    int  m_echo_s = 0, m_echo_e = 0, m_busy_s = 0, m_busy_e = 0;
    int  m_err_edge = -1;
    int  m_cnt = 0;
    bit  m_pend = 1'b0;

    sonic_echo_responder #(
        .CLK_FREQ_HZ(2000000), .TRIG_MIN_US(TMIN), .BURST_US(B_US), .US_PER_CM(UPC),
        .MIN_CM(MINC), .MAX_CM(MAXC), .TIMEOUT_US(TO_US), .HOLDOFF_US(H_US), .DIST_W(9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trigger(trigger),
        .dist_cm(dist_cm),
        .obj_present(obj_present),
        .echo(echo),
        .busy(busy),
        .trig_err(trig_err)
`ifdef SONIC_ECHO_CNT_EN
        ,
        .echo_cnt(echo_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int width_rule(input int d, input bit obj);
        if (!obj || d > MAXC) return TO_US;
        if (d < MINC) return MINC * UPC;
        return d * UPC;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: trigger sample at edge n reaches the FSM at edge n+2
    initial begin
        int k, w;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                m_prev = 1'b0; m_in_trig = 1'b0; m_idle_edge = 0;
                m_echo_s = 0; m_echo_e = 0; m_busy_s = 0; m_busy_e = 0;
                m_err_edge = -1; m_cnt = 0; m_pend = 1'b0;
            end else begin
                if (m_pend && cyc >= m_echo_e) begin
                    m_cnt++;
                    m_pend = 1'b0;
                end
                if (trigger && !m_prev && (m_idle_edge <= cyc + 1)) begin
                    m_in_trig = 1'b1;
                    m_rise = cyc;
                end
                if (!trigger && m_prev && m_in_trig) begin
                    m_in_trig = 1'b0;
                    k = cyc - m_rise;
                    if (k >= TMIN * C) begin
                        w = width_rule(int'(dist_cm), obj_present);
                        m_busy_s = cyc + 3;
                        m_echo_s = cyc + 3 + B_US * C;
                        m_echo_e = m_echo_s + w * C;
                        m_busy_e = m_echo_e + H_US * C;
                        m_idle_edge = m_busy_e - 1;
                        m_pend = 1'b1;
                    end else begin
                        m_err_edge = cyc + 2;
                        m_idle_edge = cyc + 2;
                    end
                end
                m_prev = trigger;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    initial begin
        bit obs_prev = 1'b0;
        forever begin
            @(negedge clk);
            check("echo", int'(echo), int'(rst_n && cyc >= m_echo_s && cyc < m_echo_e));
            check("busy", int'(busy), int'(rst_n && cyc >= m_busy_s && cyc < m_busy_e));
            check("trig_err", int'(trig_err), int'(rst_n && cyc == m_err_edge));
`ifdef SONIC_ECHO_CNT_EN
            check("echo_cnt", int'(echo_cnt), rst_n ? m_cnt : 0);
`endif
            if (echo && !obs_prev) rises++;
            obs_prev = echo;
        end
    end

    task automatic pulse(input int k, output int nf);
        @(negedge clk);
        trigger = 1'b1;
        repeat (k) @(negedge clk);
        trigger = 1'b0;
        nf = cyc + 1;
    endtask

    // which: 0 echo, 1 busy, 2 trig_err; returns edge number or -1 on timeout
    task automatic wait_sig(input string name, input int which, input bit val,
                            input int budget, output int t);
        bit s;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            s = (which == 0) ? echo : (which == 1) ? busy : trig_err;
            if (s == val) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_meas(input string name, input int w_cyc);
        int nf, t0, t1, t2;
        pulse(TMIN * C, nf);
        wait_sig(name, 0, 1'b1, 6000, t0);
        if (t0 >= 0) check({name, "_lat"}, t0 - nf, 43);
        wait_sig(name, 0, 1'b0, 6000, t1);
        if (t0 >= 0 && t1 >= 0) check({name, "_width"}, t1 - t0, w_cyc);
        wait_sig(name, 1, 1'b0, 6000, t2);
        if (t1 >= 0 && t2 >= 0) check({name, "_hold"}, t2 - t1, 100);
        repeat (4) @(negedge clk);
    endtask

    task automatic short_trig(input string name, input int k);
        int nf, t;
        pulse(k, nf);
        wait_sig(name, 2, 1'b1, 10, t);
        if (t >= 0) check({name, "_err_lat"}, t - nf, 2);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int nf, t0, t1, t2, r0;
        repeat (3) @(negedge clk);
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(trig_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        dist_cm = 9'd10; obj_present = 1'b1;
        run_meas("d10", 60);
        short_trig("short5us", 10);
        short_trig("short19", 19);
        check("no_echo_short", rises, 1);

        obj_present = 1'b0;
        run_meas("noobj", 3000);
        obj_present = 1'b1; dist_cm = 9'd500;
        run_meas("d500", 3000);
        dist_cm = 9'd401;
        run_meas("d401", 3000);
        dist_cm = 9'd1;
        run_meas("d1", 12);
        dist_cm = 9'd2;
        run_meas("d2", 12);
        dist_cm = 9'd400;
        run_meas("d400", 2400);

        // retrigger attempts during ECHO and across HOLDOFF end
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        r0 = rises;
        dist_cm = 9'd200; obj_present = 1'b1;
        pulse(TMIN * C, nf);
        wait_sig("re_rise", 0, 1'b1, 6000, t0);
        repeat (100) @(negedge clk);
        dist_cm = 9'd5; obj_present = 1'b0;
        pulse(30, t2);
        wait_sig("re_fall", 0, 1'b0, 6000, t1);
        if (t0 >= 0 && t1 >= 0) check("re_width", t1 - t0, 1200);
        repeat (20) @(negedge clk);
        trigger = 1'b1;
        wait_sig("re_busy", 1, 1'b0, 6000, t2);
        repeat (30) @(negedge clk);
        trigger = 1'b0;
        repeat (50) @(negedge clk);
        check("re_single", rises - r0, 1);
        dist_cm = 9'd10; obj_present = 1'b1;
        run_meas("re_new", 60);
        check("re_two", rises - r0, 2);
`ifdef SONIC_ECHO_CNT_EN
        check("cnt_two", int'(echo_cnt), 2);
`endif

        // asynchronous reset in the middle of an echo
        dist_cm = 9'd100;
        pulse(TMIN * C, nf);
        wait_sig("ar_rise", 0, 1'b1, 6000, t0);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_echo", int'(echo), 0);
        check("ar_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        dist_cm = 9'd10;
        run_meas("ar_after", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
